// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: strobe/data in, FIFO space and fill level out.
// Signal names are given from the transmitter's point of view.
interface uart_tx_fifo_if #(parameter int FIFO_DEPTH = 4);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  logic          i_TX_DV;
  logic [7:0]    i_TX_Byte;
  logic          o_TX_Ready;
  logic [NW-1:0] o_FIFO_Count;

  modport master (output i_TX_DV, i_TX_Byte, input  o_TX_Ready, o_FIFO_Count);
  modport slave  (input  i_TX_DV, i_TX_Byte, output o_TX_Ready, o_FIFO_Count);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, with a small byte FIFO so writers can queue bytes.
// A queued byte is picked up at the end of the stop bit, so frames run back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  uart_tx_fifo_if.slave   wr,
  output logic            o_TX_Active,
  output logic            o_TX_Serial,
  output logic            o_TX_Done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;
  logic          push, pop, bit_end, have_byte;

  assign wr.o_TX_Ready   = (count_q != NW'(FIFO_DEPTH));
  assign wr.o_FIFO_Count = count_q;
  assign push            = wr.i_TX_DV && wr.o_TX_Ready;
  assign have_byte       = (count_q != '0);
  assign bit_end         = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= wr.i_TX_Byte;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        serial_d  = 1'b1;
        if (have_byte) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          state_d  = START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit when another byte is waiting.
          if (have_byte) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Two transmitters (2 and 5 clocks per bit) share one randomized write stream; each has a
// frame-timing model feeding an expected-byte queue and a line decoder that checks it.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int NW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  int checks = 0;
  int errors = 0;
  int busy[2];
  int leftover[2];

  logic [1:0]         ser_w, act_w, done_w, rdy_w;
  logic [1:0][NW-1:0] cnt_w;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, g, $time, got, exp);
    end
  endtask

  for (genvar G = 0; G < 2; G++) begin : gi
    localparam int CPB = (G == 0) ? 2 : 5;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) ifc();
    logic ser, act, dn;

    assign ifc.i_TX_DV   = dv;
    assign ifc.i_TX_Byte = tx_byte;
    assign ser_w[G]  = ser;
    assign act_w[G]  = act;
    assign done_w[G] = dn;
    assign rdy_w[G]  = ifc.o_TX_Ready;
    assign cnt_w[G]  = ifc.o_FIFO_Count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock(clk), .i_Rst_L(rst_n), .wr(ifc),
      .o_TX_Active(act), .o_TX_Serial(ser), .o_TX_Done(dn)
    );

    logic [7:0] q[$];
    logic [7:0] expq[$];
    int rem = 0;
    int epoch = 0;
    logic exp_done = 1'b0;

    // Model: rem = cycles left in the frame on the line; a queued byte starts a frame when
    // the line is idle or during the frame's final cycle.
    initial begin
      int sz;
      bit pop, ended;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete(); expq.delete();
          rem = 0; exp_done = 1'b0; epoch++;
          busy[G] = 0; leftover[G] = 0;
          continue;
        end
        sz    = q.size();
        pop   = (sz > 0) && (rem <= 1);
        ended = (rem == 1);
        if (rem > 0) rem--;
        if (pop) begin
          expq.push_back(q.pop_front());
          rem = 10 * CPB;
        end
        if (dv && sz < DEPTH) q.push_back(tx_byte);
        exp_done    = ended;
        busy[G]     = rem + q.size();
        leftover[G] = expq.size();
        @(negedge clk);
        if (rst_n) begin
          chk("count", G, 32'(ifc.o_FIFO_Count), 32'(q.size()));
          chk("ready", G, 32'(ifc.o_TX_Ready), 32'(q.size() < DEPTH));
          chk("active", G, 32'(act), 32'(rem > 0));
          chk("done", G, 32'(dn), 32'(exp_done));
        end
      end
    end

    // Line decoder: find a start bit, sample each bit mid-cell, compare with the queue head.
    initial begin
      int ep;
      logic [9:0] bits;
      logic [7:0] e;
      forever begin
        @(negedge clk);
        if (!rst_n || ser !== 1'b0) continue;
        ep = epoch;
        repeat (CPB / 2) @(negedge clk);
        bits[0] = ser;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) @(negedge clk);
          bits[k] = ser;
        end
        if (ep != epoch || !rst_n) continue;
        if (expq.size() == 0) begin
          chk("unexpected_frame", G, 32'(bits), 32'h0);
        end else begin
          e = expq.pop_front();
          leftover[G] = expq.size();
          chk("frame", G, 32'(bits), {22'h0, 1'b1, e, 1'b0});
        end
      end
    end
  end

  task automatic wr_seq(input logic [7:0] b);
    dv = 1'b1; tx_byte = b;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy[0] != 0 || busy[1] != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 0, 32'(n >= max), 32'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_serial"}, g, 32'(ser_w[g]), 32'h1);
      chk({tag, "_active"}, g, 32'(act_w[g]), 32'h0);
      chk({tag, "_done"}, g, 32'(done_w[g]), 32'h0);
      chk({tag, "_count"}, g, 32'(cnt_w[g]), 32'h0);
      chk({tag, "_ready"}, g, 32'(rdy_w[g]), 32'h1);
    end
  endtask

  initial begin
    logic [7:0] burst [4];
    burst = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    repeat (3) @(negedge clk);
    #1 chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, then a 4-byte burst on consecutive cycles.
    wr_seq(8'h37);
    wait_idle(200);
    for (int i = 0; i < 4; i++) begin
      dv = 1'b1; tx_byte = burst[i];
      @(negedge clk);
    end
    dv = 1'b0;
    wait_idle(600);

    // Overflow: one frame on the line, then five writes; the fifth is dropped.
    wr_seq(8'h80);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dv = 1'b1; tx_byte = 8'h10 + 8'(i);
      @(negedge clk);
    end
    dv = 1'b0;
    wait_idle(600);

    // Asynchronous reset in the middle of a frame.
    wr_seq(8'h5A);
    wr_seq(8'hC3);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Random write stream; dense enough to fill the FIFO and hit push+pop on one edge.
    for (int i = 0; i < 3000; i++) begin
      dv = ($urandom_range(0, 3) == 0);
      tx_byte = 8'($urandom);
      @(negedge clk);
    end
    dv = 1'b0;
    wait_idle(2000);
    repeat (5) @(negedge clk);
    chk("leftover", 0, 32'(leftover[0]), 32'h0);
    chk("leftover", 1, 32'(leftover[1]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
